// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ write-domain requesters.
// Each grant is a burst of up to BURST_LEN words; FULL stalls the burst without losing the grant.
//
// state | meaning
// IDLE  | no grant; pick the next requester after LAST, grant it at the next edge
// BURST | requester g owns the write port; a word moves whenever REQ[g] & ~FULL
module fifo_wr_arbiter #(
    parameter int Data_width = 8,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                          W_CLK,
    input  logic                          W_RST,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ*Data_width-1:0] REQ_DATA,
    input  logic                          FULL,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            ACK,
    output logic                          W_INC,
    output logic [Data_width-1:0]         WR_DATA,
    output logic                          BUSY
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   gnt, gnt_nxt;
    logic [IW-1:0]        g_idx, g_nxt;
    logic [IW-1:0]        last, last_nxt;
    logic [CW-1:0]        count, count_nxt;

    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        sel_hi;
    logic [IW-1:0]        sel_lo;
    logic                 found_hi;
    logic                 req_g;
    logic                 xfer;

    // Round-robin search: lowest requester above LAST wins, else wrap to the lowest at or below it.
    always_comb begin
        found_hi = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ[i]) begin
                if (IW'(i) > last) begin
                    found_hi = 1'b1;
                    sel_hi   = IW'(i);
                end else begin
                    sel_lo = IW'(i);
                end
            end
        end
        sel_idx = found_hi ? sel_hi : sel_lo;
    end

    // gnt is zero outside BURST, so req_g/xfer need no separate state qualifier for ACK.
    assign BUSY  = (state == BURST);
    assign req_g = |(REQ & gnt);
    assign xfer  = BUSY & req_g & ~FULL;
    assign W_INC = xfer;
    assign ACK   = xfer ? gnt : '0;
    assign GNT   = gnt;

    always_comb begin
        WR_DATA = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && (g_idx == IW'(i))) begin
                WR_DATA = REQ_DATA[i*Data_width +: Data_width];
            end
        end
    end

    always_ff @(posedge W_CLK or negedge W_RST) begin
        if (!W_RST) begin
            state <= IDLE;
            gnt   <= '0;
            g_idx <= '0;
            last  <= IDX_LAST;
            count <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            g_idx <= g_nxt;
            last  <= last_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        g_nxt     = g_idx;
        last_nxt  = last;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (|REQ) begin
                    state_nxt = BURST;
                    gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    g_nxt     = sel_idx;
                    count_nxt = '0;
                end
            end
            BURST: begin
                // A FULL stall (req_g & FULL) falls through with everything held.
                if (!req_g || (xfer && (count == CNT_LAST))) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    last_nxt  = g_idx;
                    count_nxt = '0;
                end else if (xfer) begin
                    count_nxt = count + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                count_nxt = '0;
            end
        endcase
    end

    a_no_write_when_full : assert property (@(posedge W_CLK) disable iff (!W_RST) !(W_INC && FULL));
    a_gnt_onehot0        : assert property (@(posedge W_CLK) disable iff (!W_RST) $onehot0(GNT));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO read side on a 25 ns clock.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    logic        W_CLK = 1'b0;
    logic        R_CLK = 1'b0;
    logic        W_RST = 1'b0;
    logic [3:0]  REQ = '0;
    logic [31:0] REQ_DATA = '0;
    logic        FULL = 1'b0;
    logic [3:0]  GNT;
    logic [3:0]  ACK;
    logic        W_INC;
    logic [7:0]  WR_DATA;
    logic        BUSY;

    fifo_wr_arbiter #(.Data_width(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
        .W_CLK(W_CLK), .W_RST(W_RST), .REQ(REQ), .REQ_DATA(REQ_DATA), .FULL(FULL),
        .GNT(GNT), .ACK(ACK), .W_INC(W_INC), .WR_DATA(WR_DATA), .BUSY(BUSY)
    );

    always #5 W_CLK = ~W_CLK;
    always begin
        #12 R_CLK = 1'b1;
        #13 R_CLK = 1'b0;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [3:0] ack_s, gnt_s;
    logic       winc_s, busy_s;
    logic [7:0] data_s;
    logic [5:0] seq [4];
    logic [5:0] rd_seq [4];
    bit         model_en = 1'b0;
    bit         push_en = 1'b0;
    logic [7:0] fifo [$];
    int         n_wr = 0;
    int         n_rd = 0;
    logic [7:0] rd_w;

    task automatic drive_data();
        for (int i = 0; i < 4; i++) REQ_DATA[i*8 +: 8] = {2'(i), seq[i]};
    endtask

    // One cycle: sample at the falling edge, then return 1 ns after the next rising edge.
    task automatic step();
        @(negedge W_CLK);
        ack_s  = ACK;
        gnt_s  = GNT;
        winc_s = W_INC;
        data_s = WR_DATA;
        busy_s = BUSY;
        chk("inv_full", {31'b0, winc_s & FULL}, 32'd0);
        chk("inv_winc_ack", {31'b0, winc_s}, {31'b0, |ack_s});
        chk("inv_ack_gnt", {28'b0, ack_s & ~gnt_s}, 32'd0);
        if (model_en) begin
            for (int i = 0; i < 4; i++)
                if (ack_s[i]) chk("ack_data", {24'b0, data_s}, {24'b0, 2'(i), seq[i]});
        end
        if (push_en && winc_s) begin
            fifo.push_back(data_s);
            n_wr++;
        end
        @(posedge W_CLK);
        #1;
        if (model_en) begin
            for (int i = 0; i < 4; i++) if (ack_s[i]) seq[i] = seq[i] + 6'd1;
            drive_data();
        end
    endtask

    task automatic do_reset();
        W_RST = 1'b0;
        REQ   = '0;
        FULL  = 1'b0;
        #3;
        @(posedge W_CLK);
        #1;
        W_RST = 1'b1;
    endtask

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    always @(posedge R_CLK) begin
        if (push_en && fifo.size() > 0) begin
            rd_w = fifo.pop_front();
            chk("rd_order", {26'b0, rd_w[5:0]}, {26'b0, rd_seq[rd_w[7:6]]});
            rd_seq[rd_w[7:6]] = rd_seq[rd_w[7:6]] + 6'd1;
            n_rd++;
        end
    end

    initial begin
        logic [7:0] t1w [4];
        int         exp_cnt [4];
        int         nw;
        int         o;

        t1w = '{8'hAA, 8'hBC, 8'h6F, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            seq[i] = '0;
            rd_seq[i] = '0;
            exp_cnt[i] = 0;
        end

        // Reset values
        #7;
        chk("rst_gnt", {28'b0, GNT}, 32'd0);
        chk("rst_ack", {28'b0, ACK}, 32'd0);
        chk("rst_winc", {31'b0, W_INC}, 32'd0);
        chk("rst_busy", {31'b0, BUSY}, 32'd0);
        chk("rst_data", {24'b0, WR_DATA}, 32'd0);
        @(posedge W_CLK);
        #1;
        W_RST = 1'b1;

        // Single requester, full burst of four
        REQ_DATA[7:0] = 8'hAA;
        REQ = 4'b0001;
        step();
        chk("t1_idle_gnt", {28'b0, gnt_s}, 32'd0);
        chk("t1_idle_winc", {31'b0, winc_s}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_gnt", {28'b0, gnt_s}, 32'h1);
            chk("t1_winc", {31'b0, winc_s}, 32'd1);
            chk("t1_data", {24'b0, data_s}, {24'b0, t1w[k]});
            if (k < 3) REQ_DATA[7:0] = t1w[k+1];
            else REQ = 4'b0000;
        end
        step();
        chk("t1_end_gnt", {28'b0, gnt_s}, 32'd0);
        chk("t1_end_busy", {31'b0, busy_s}, 32'd0);

        // All four requesting: order 0,1,2,3,0 with one idle cycle between bursts
        do_reset();
        for (int i = 0; i < 4; i++) seq[i] = '0;
        model_en = 1'b1;
        drive_data();
        REQ = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            o = b % 4;
            step();
            chk("t2_idle_gnt", {28'b0, gnt_s}, 32'd0);
            chk("t2_idle_winc", {31'b0, winc_s}, 32'd0);
            for (int k = 0; k < 4; k++) begin
                step();
                chk("t2_gnt", {28'b0, gnt_s}, oh(o));
                chk("t2_winc", {31'b0, winc_s}, 32'd1);
                chk("t2_data", {24'b0, data_s}, {24'b0, 2'(o), 6'(exp_cnt[o])});
                exp_cnt[o]++;
            end
        end
        REQ = 4'b0000;
        step();

        // FULL stall in the middle of requester 2's burst
        do_reset();
        for (int i = 0; i < 4; i++) seq[i] = '0;
        drive_data();
        REQ = 4'b0100;
        nw = 0;
        step();
        chk("t3_idle_gnt", {28'b0, gnt_s}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            nw += int'(winc_s);
            chk("t3_gnt", {28'b0, gnt_s}, 32'h4);
            chk("t3_data", {24'b0, data_s}, {24'b0, 2'd2, 6'(k)});
        end
        FULL = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            nw += int'(winc_s);
            chk("t3_stall_winc", {31'b0, winc_s}, 32'd0);
            chk("t3_stall_ack", {28'b0, ack_s}, 32'd0);
            chk("t3_stall_gnt", {28'b0, gnt_s}, 32'h4);
        end
        FULL = 1'b0;
        for (int k = 2; k < 4; k++) begin
            step();
            nw += int'(winc_s);
            chk("t3_gnt", {28'b0, gnt_s}, 32'h4);
            chk("t3_data", {24'b0, data_s}, {24'b0, 2'd2, 6'(k)});
        end
        REQ = 4'b0000;
        step();
        nw += int'(winc_s);
        chk("t3_end_gnt", {28'b0, gnt_s}, 32'd0);
        chk("t3_total", nw, 32'd4);

        // Requester 1 drops early; next grant must rotate past it to 2
        do_reset();
        REQ = 4'b0010;
        step();
        chk("t4_idle_gnt", {28'b0, gnt_s}, 32'd0);
        step();
        chk("t4_gnt", {28'b0, gnt_s}, 32'h2);
        chk("t4_winc", {31'b0, winc_s}, 32'd1);
        REQ = 4'b0100;
        step();
        chk("t4_drop_gnt", {28'b0, gnt_s}, 32'h2);
        chk("t4_drop_winc", {31'b0, winc_s}, 32'd0);
        chk("t4_drop_busy", {31'b0, busy_s}, 32'd1);
        REQ = 4'b0110;
        step();
        chk("t4_gap_gnt", {28'b0, gnt_s}, 32'd0);
        chk("t4_gap_busy", {31'b0, busy_s}, 32'd0);
        step();
        chk("t4_next_gnt", {28'b0, gnt_s}, 32'h4);
        chk("t4_next_winc", {31'b0, winc_s}, 32'd1);

        // Asynchronous reset during requester 1's burst
        do_reset();
        REQ = 4'b1111;
        for (int k = 0; k < 7; k++) step();
        chk("t5_pre_winc", {31'b0, W_INC}, 32'd1);
        chk("t5_pre_gnt", {28'b0, GNT}, 32'h2);
        #2;
        W_RST = 1'b0;
        #1;
        chk("t5_rst_winc", {31'b0, W_INC}, 32'd0);
        chk("t5_rst_gnt", {28'b0, GNT}, 32'd0);
        chk("t5_rst_ack", {28'b0, ACK}, 32'd0);
        chk("t5_rst_busy", {31'b0, BUSY}, 32'd0);
        @(posedge W_CLK);
        #1;
        W_RST = 1'b1;
        step();
        chk("t5_idle_gnt", {28'b0, gnt_s}, 32'd0);
        step();
        chk("t5_first_gnt", {28'b0, gnt_s}, 32'h1);

        // Random REQ/FULL traffic against an 8-deep FIFO drained at 25 ns
        do_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = '0;
            rd_seq[i] = '0;
        end
        fifo.delete();
        n_wr = 0;
        n_rd = 0;
        drive_data();
        push_en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            REQ  = 4'($urandom_range(0, 15));
            FULL = (fifo.size() >= 8) || ($urandom_range(0, 3) == 0);
            step();
            chk("t6_depth", {31'b0, fifo.size() > 8}, 32'd0);
        end
        REQ  = 4'b0000;
        FULL = 1'b0;
        step();
        for (int t = 0; t < 60 && fifo.size() > 0; t++) @(posedge W_CLK);
        chk("t6_drain", fifo.size(), 32'd0);
        chk("t6_count", n_rd, n_wr);
        chk("t6_traffic", {31'b0, n_wr > 20}, 32'd1);
        push_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
